pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Supervises the `rst`/`locked` interface of the PLL wrapper from the controller side. It pulses the PLL reset, waits for and filters the `locked` indication, and retries the PLL if lock never comes. It holds the system reset until lock has been stable for a programmable time, and re-sequences on any lock loss. It runs on the free-running board reference clock, sits between the board clock/reset pins and the PLL instance, and feeds the core's reset tree.

## Interface
Parameters:
- `PLL_RST_LEN`, default 16: refclk cycles `pll_rst` is held high per PLL reset pulse (≥1).
- `TIMEOUT`, default 50000: refclk cycles allowed from PLL reset release to accepted lock before retrying (≥ LOCK_FILT+1).
- `LOCK_FILT`, default 1024: consecutive synchronized-high cycles of `pll_locked` required to accept lock (≥1).
- `RST_HOLD`, default 64: refclk cycles `sys_rst_n` is held low after lock acceptance (≥1).
- `CNT_W`, default 8: width of the status counters.

Ports:
- `refclk`  in  1  free-running reference clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pll_locked`  in  1  PLL `locked` output; asynchronous; 2-flop synchronized internally (`locked_s`).
- `pll_rst`  out  1  active-high reset to the PLL `rst` input; registered.
- `sys_rst_n`  out  1  active-low system reset; registered; deassertion must be resynchronized by the consumer into `outclk_0`.
- `ready`  out  1  high only in RUN; registered.
- `retry_cnt`  out  CNT_W  saturating count of lock timeouts.
- `loss_cnt`  out  CNT_W  saturating count of lock losses after acceptance.

## Operation
- Reset values: state PLL_RST, `pll_rst`=1, `sys_rst_n`=0, `ready`=0, both counters 0, synchronizer flops 0, all timers 0.
- States: PLL_RST, WAIT_LOCK, FILTER, HOLD, RUN.
- PLL_RST: `pll_rst`=1. After PLL_RST_LEN cycles → WAIT_LOCK. Clear `wait_cnt`.
- WAIT_LOCK: `pll_rst`=0, `wait_cnt` increments.
  - If `locked_s`=1 → FILTER, clearing `filt_cnt`.
  - If `wait_cnt` reaches TIMEOUT → PLL_RST and `retry_cnt`++ (saturating at 2^CNT_W−1).
- FILTER: `wait_cnt` keeps incrementing; it is not cleared by FILTER dropouts, so chattering lock still times out.
  - If `locked_s`=0 → WAIT_LOCK.
  - Else if `filt_cnt` reaches LOCK_FILT → HOLD.
  - Timeout is checked as in WAIT_LOCK and takes priority over both conditions above.
- HOLD: `sys_rst_n`=0. After RST_HOLD cycles → RUN.
- RUN: `sys_rst_n`=1, `ready`=1.
- Lock loss: `locked_s`=0 in HOLD or RUN → PLL_RST and `loss_cnt`++ (saturating). `sys_rst_n`=0 and `ready`=0 on the same edge that `pll_rst` rises.
- Counters are never cleared except by `reset_n`.
- Outputs are decoded from the next state and registered.

## Timing
- `reset_n` low asynchronously forces the reset values. Release is synchronous to the next `refclk` edge.
- After `reset_n` release, `pll_rst` is high for exactly PLL_RST_LEN edges, then low.
- Synchronizer latency: `locked_s` follows `pll_locked` 2 edges later.
- Lock acceptance: with `pll_locked` high from edge E onward, `sys_rst_n` and `ready` rise on edge E+3+LOCK_FILT+RST_HOLD.
- Timeout: `pll_rst` re-rises exactly TIMEOUT edges after it fell, if lock was not accepted.
- Lock loss: `pll_locked` falling sampled at edge E gives `pll_rst`=1, `sys_rst_n`=0 and `ready`=0 at edge E+3.
- Simultaneous timeout and `locked_s` rising in WAIT_LOCK: timeout wins.

## Test plan
Use PLL_RST_LEN=3, TIMEOUT=20, LOCK_FILT=4, RST_HOLD=5, CNT_W=2.
- Release `reset_n`, hold `pll_locked`=0 → `pll_rst` high 3 cycles, low 20 cycles, high 3 again; `retry_cnt` reads 1, then 2, then saturates at 3; `sys_rst_n` stays 0.
- `pll_locked`=1 from edge E after the first reset pulse → `sys_rst_n` and `ready` rise at E+12; `retry_cnt`=0.
- Toggle `pll_locked` high 2 cycles / low 1 cycle repeatedly → never reaches HOLD; `pll_rst` re-rises 20 cycles after it fell; `retry_cnt`=1.
- In RUN, drop `pll_locked` at edge E → at E+3 `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `loss_cnt`=1; restoring lock returns to RUN on the same timing as the acceptance scenario.
- Five lock losses in sequence → `loss_cnt`=3 (saturated).
- Assert `reset_n` mid-RUN and mid-HOLD → `sys_rst_n`=0, `ready`=0, `pll_rst`=1 and both counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses the PLL reset, filters the locked indication,
// retries on lock timeout and releases the system reset once lock is stable.
module pll_lock_supervisor #(
  parameter int PLL_RST_LEN = 16,
  parameter int TIMEOUT     = 50000,
  parameter int LOCK_FILT   = 1024,
  parameter int RST_HOLD    = 64,
  parameter int CNT_W       = 8
) (
  input  logic             refclk,
  input  logic             reset_n,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_FILTER    = 3'd2;
  localparam logic [2:0] S_HOLD      = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;

  localparam int RST_W  = $clog2(PLL_RST_LEN + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int FILT_W = $clog2(LOCK_FILT + 1);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  // Each timer leaves its state on the edge its count would reach the limit.
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RST_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  logic              locked_m;
  logic              locked_s;
  logic [2:0]        state_q,    state_d;
  logic [RST_W-1:0]  rst_cnt_q,  rst_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              retry_inc;
  logic              loss_inc;
  logic              timeout;

  // pll_locked comes from the PLL's own clocking; two flops before any use.
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= pll_locked;
      locked_s <= locked_m;
    end
  end

  assign timeout = (wait_cnt_q == WAIT_LAST);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    wait_cnt_d = wait_cnt_q;
    filt_cnt_d = filt_cnt_q;
    hold_cnt_d = hold_cnt_q;
    retry_inc  = 1'b0;
    loss_inc   = 1'b0;

    case (state_q)
      S_PLL_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d    = S_WAIT_LOCK;
          wait_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      // wait_cnt spans both states so a chattering lock still times out.
      S_WAIT_LOCK, S_FILTER: begin
        if (timeout) begin
          state_d   = S_PLL_RST;
          rst_cnt_d = '0;
          retry_inc = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (state_q == S_WAIT_LOCK) begin
            if (locked_s) begin
              state_d    = S_FILTER;
              filt_cnt_d = '0;
            end
          end else if (!locked_s) begin
            state_d = S_WAIT_LOCK;
          end else if (filt_cnt_q == FILT_LAST) begin
            state_d    = S_HOLD;
            hold_cnt_d = '0;
          end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (!locked_s) begin
          state_d   = S_PLL_RST;
          rst_cnt_d = '0;
          loss_inc  = 1'b1;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        if (!locked_s) begin
          state_d   = S_PLL_RST;
          rst_cnt_d = '0;
          loss_inc  = 1'b1;
        end
      end

      default: begin
        state_d   = S_PLL_RST;
        rst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_PLL_RST;
      rst_cnt_q  <= '0;
      wait_cnt_q <= '0;
      filt_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      filt_cnt_q <= filt_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Status counters saturate and only reset_n clears them.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      if (retry_inc && (retry_cnt != '1)) retry_cnt <= retry_cnt + 1'b1;
      if (loss_inc && (loss_cnt != '1))   loss_cnt  <= loss_cnt + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      pll_rst   <= (state_d == S_PLL_RST);
      sys_rst_n <= (state_d == S_RUN);
      ready     <= (state_d == S_RUN);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: timestamp-based reference model
// compared every cycle, plus directed literal checks of the key timings.
module tb_pll_lock_supervisor;

  localparam int PLL_RST_LEN = 3;
  localparam int TIMEOUT     = 20;
  localparam int LOCK_FILT   = 4;
  localparam int RST_HOLD    = 5;
  localparam int CNT_W       = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             refclk = 1'b0;
  logic             reset_n = 1'b0;
  logic             pll_locked = 1'b0;
  logic             pll_rst;
  logic             sys_rst_n;
  logic             ready;
  logic [CNT_W-1:0] retry_cnt;
  logic [CNT_W-1:0] loss_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  pll_lock_supervisor #(
    .PLL_RST_LEN(PLL_RST_LEN),
    .TIMEOUT    (TIMEOUT),
    .LOCK_FILT  (LOCK_FILT),
    .RST_HOLD   (RST_HOLD),
    .CNT_W      (CNT_W)
  ) dut (
    .refclk    (refclk),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt)
  );

  always #5 refclk = ~refclk;

  // Reference model: phases with entry/fall timestamps in edges since release.
  typedef enum {M_RST, M_WAIT, M_FILT, M_HOLD, M_RUN} mphase_t;
  mphase_t ph      = M_RST;
  int      n_edge  = 0;
  int      t_enter = 0;
  int      t_fall  = 0;
  bit      lk0     = 1'b0;
  bit      lk1     = 1'b0;
  int      m_retry = 0;
  int      m_loss  = 0;

  task automatic model_reset();
    ph = M_RST; n_edge = 0; t_enter = 0; t_fall = 0;
    lk0 = 1'b0; lk1 = 1'b0; m_retry = 0; m_loss = 0;
  endtask

  task automatic model_edge();
    bit ls;
    n_edge++;
    ls  = lk1;
    lk1 = lk0;
    lk0 = pll_locked;
    case (ph)
      M_RST: if (n_edge - t_enter == PLL_RST_LEN) begin ph = M_WAIT; t_fall = n_edge; end
      M_WAIT, M_FILT: begin
        if (n_edge - t_fall == TIMEOUT) begin
          ph = M_RST; t_enter = n_edge;
          if (m_retry < CNT_MAX) m_retry++;
        end else if (ph == M_WAIT) begin
          if (ls) begin ph = M_FILT; t_enter = n_edge; end
        end else if (!ls) begin
          ph = M_WAIT;
        end else if (n_edge - t_enter == LOCK_FILT) begin
          ph = M_HOLD; t_enter = n_edge;
        end
      end
      M_HOLD, M_RUN: begin
        if (!ls) begin
          ph = M_RST; t_enter = n_edge;
          if (m_loss < CNT_MAX) m_loss++;
        end else if (ph == M_HOLD && n_edge - t_enter == RST_HOLD) begin
          ph = M_RUN;
        end
      end
      default: ph = M_RST;
    endcase
  endtask

  initial forever begin
    @(posedge refclk or negedge reset_n);
    if (!reset_n) model_reset();
    else          model_edge();
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge refclk) begin
    if (cmp_en) begin
      logic [2:0] exp_bits;
      exp_bits = {ph == M_RST, ph == M_RUN, ph == M_RUN};
      n_cmp++;
      if ({pll_rst, sys_rst_n, ready} !== exp_bits ||
          retry_cnt !== CNT_W'(m_retry) || loss_cnt !== CNT_W'(m_loss)) begin
        n_bad++;
        if (n_bad <= 20)
          $display("FAIL model t=%0t: got rst/sys/rdy=%b%b%b retry=%0d loss=%0d, expected %b retry=%0d loss=%0d",
                   $time, pll_rst, sys_rst_n, ready, retry_cnt, loss_cnt, exp_bits, m_retry, m_loss);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cyc %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    repeat (2) @(posedge refclk);
    #1;
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1 cmp_en = 1'b1;

    // No lock: pulse/timeout cadence and retry saturation.
    do_reset();
    check("reset pll_rst", pll_rst, 1);
    check("reset sys_rst_n", sys_rst_n, 0);
    check("reset retry_cnt", retry_cnt, 0);
    run_to(2);  check("pulse high edge2", pll_rst, 1);
    run_to(3);  check("pulse low edge3", pll_rst, 0);
    run_to(22); check("still waiting edge22", pll_rst, 0);
                check("retry before timeout", retry_cnt, 0);
    run_to(23); check("timeout re-rise", pll_rst, 1);
                check("retry 1", retry_cnt, 1);
    run_to(25); check("second pulse high", pll_rst, 1);
    run_to(26); check("second pulse low", pll_rst, 0);
    run_to(46); check("retry 2", retry_cnt, 2);
    run_to(69); check("retry 3", retry_cnt, 3);
    run_to(92); check("retry saturated", retry_cnt, 3);
                check("no lock sys_rst_n", sys_rst_n, 0);

    // Lock from edge 5: RUN at 5+12.
    do_reset();
    run_to(5);  pll_locked = 1'b1;
    run_to(16); check("accept sys_rst_n pre", sys_rst_n, 0);
                check("accept ready pre", ready, 0);
    run_to(17); check("accept sys_rst_n", sys_rst_n, 1);
                check("accept ready", ready, 1);
                check("accept retry", retry_cnt, 0);

    // Lock loss at edge 20, restored at edge 24.
    run_to(20); pll_locked = 1'b0;
    run_to(22); check("loss pre pll_rst", pll_rst, 0);
                check("loss pre ready", ready, 1);
    run_to(23); check("loss pll_rst", pll_rst, 1);
                check("loss sys_rst_n", sys_rst_n, 0);
                check("loss ready", ready, 0);
                check("loss cnt 1", loss_cnt, 1);
    run_to(24); pll_locked = 1'b1;
    run_to(35); check("relock ready pre", ready, 0);
    run_to(36); check("relock ready", ready, 1);
                check("relock sys_rst_n", sys_rst_n, 1);

    // Four more losses: loss_cnt saturates at 3.
    for (int k = 0; k < 4; k++) begin
      int c0;
      c0 = 40 + 20 * k;
      run_to(c0);      pll_locked = 1'b0;
      run_to(c0 + 3);  check("multi loss pll_rst", pll_rst, 1);
                       check("multi loss cnt", loss_cnt, (k == 0) ? 2 : 3);
      run_to(c0 + 4);  pll_locked = 1'b1;
      run_to(c0 + 16); check("multi relock ready", ready, 1);
    end

    // Asynchronous reset in RUN.
    run_to(125);
    #2 reset_n = 1'b0;
    #1;
    check("async run pll_rst", pll_rst, 1);
    check("async run sys_rst_n", sys_rst_n, 0);
    check("async run ready", ready, 0);
    check("async run loss_cnt", loss_cnt, 0);
    check("async run retry_cnt", retry_cnt, 0);

    // Chattering lock (2 high / 1 low) never passes the filter.
    do_reset();
    for (int c = 0; c < 23; c++) begin
      pll_locked = ((c % 3) != 2);
      tick();
      if (cyc == 22) check("chatter no retry yet", pll_rst, 0);
    end
    check("chatter timeout", pll_rst, 1);
    check("chatter retry", retry_cnt, 1);
    check("chatter sys_rst_n", sys_rst_n, 0);
    pll_locked = 1'b0;

    // One timeout, then lock; asynchronous reset in HOLD.
    do_reset();
    run_to(24); pll_locked = 1'b1;
    run_to(33); check("hold sys_rst_n", sys_rst_n, 0);
                check("hold pll_rst", pll_rst, 0);
                check("hold retry", retry_cnt, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async hold pll_rst", pll_rst, 1);
    check("async hold sys_rst_n", sys_rst_n, 0);
    check("async hold ready", ready, 0);
    check("async hold retry_cnt", retry_cnt, 0);
    check("async hold loss_cnt", loss_cnt, 0);

    repeat (2) @(posedge refclk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
